// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-cathode
// multi-digit 7-segment display sharing one external BCD decoder.
// Each digit slot starts with a blank interval. Leading zeros can be
// suppressed. New values are committed only at frame boundaries.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 2,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 500,
   parameter int BLANK_LEAD = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_data,
   output logic                    load_ack,
   output logic [3:0]              bcd_out,
   input  logic [7:0]              seg_in,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_sel
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [IW-1:0]           idx;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] pend_reg;
   logic                    pending;

   logic                    cnt_wrap;
   logic                    frame_end;
   logic                    in_blank;
   logic                    suppress;
   logic [3:0]              nib;

   assign cnt_wrap  = (cnt == CNT_LAST);
   assign frame_end = cnt_wrap && (idx == IDX_LAST);
   assign in_blank  = (cnt < BLANK_END);

   // Slot counter and digit index: cnt runs every cycle, idx advances on wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         if (cnt_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Load capture and frame-boundary commit; a load on the boundary edge is
   // captured after the commit of the older pending value
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow   <= '0;
         pend_reg <= '0;
         pending  <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= frame_end && pending;
         if (frame_end && pending) begin
            shadow  <= pend_reg;
            pending <= 1'b0;
         end
         if (load) begin
            pend_reg <= bcd_data;
            pending  <= 1'b1;
         end
      end
   end

   // Active nibble select and leading-zero detection for the active digit
   always_comb begin
      logic nonzero_above;
      nib           = '0;
      nonzero_above = 1'b0;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         if (idx == IW'(d))
            nib = shadow[4*d +: 4];
         if ((IW'(d) >= idx) && (shadow[4*d +: 4] != 4'd0))
            nonzero_above = 1'b1;
      end
      suppress = (BLANK_LEAD != 0) && (idx != '0) && !nonzero_above;
   end

   // Output drive: dark during reset and blank interval, otherwise one-hot digit
   always_comb begin
      bcd_out   = '0;
      seg_out   = '0;
      digit_sel = '0;
      if (!rst) begin
         bcd_out = nib;
         if (!in_blank) begin
            digit_sel[idx] = 1'b1;
            seg_out        = suppress ? 8'h00 : seg_in;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: NUM_DIGITS=2, SCAN_DIV=4, BLANK_CYC=1,
// with a standard decoder attached. Two instances differ only in BLANK_LEAD.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] bcd_data;

   logic       load_ack,  load_ack0;
   logic [3:0] bcd_out,   bcd_out0;
   logic [7:0] seg_in,    seg_in0;
   logic [7:0] seg_out,   seg_out0;
   logic [1:0] digit_sel, digit_sel0;

   int n_pass   = 0;
   int n_checks = 0;
   int k        = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] dec(input logic [3:0] n);
      case (n)
         4'h0: dec = 8'h3F; 4'h1: dec = 8'h06; 4'h2: dec = 8'h5B; 4'h3: dec = 8'h4F;
         4'h4: dec = 8'h66; 4'h5: dec = 8'h6D; 4'h6: dec = 8'h7D; 4'h7: dec = 8'h07;
         4'h8: dec = 8'h7F; 4'h9: dec = 8'h6F; 4'hA: dec = 8'h77; 4'hB: dec = 8'h7C;
         4'hC: dec = 8'h39; 4'hD: dec = 8'h5E; 4'hE: dec = 8'h79; default: dec = 8'h71;
      endcase
   endfunction

   assign seg_in  = dec(bcd_out);
   assign seg_in0 = dec(bcd_out0);

   seg_scan_ctrl #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LEAD(1)) dut (
      .clk(clk), .rst(rst), .load(load), .bcd_data(bcd_data), .load_ack(load_ack),
      .bcd_out(bcd_out), .seg_in(seg_in), .seg_out(seg_out), .digit_sel(digit_sel)
   );

   seg_scan_ctrl #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LEAD(0)) dut0 (
      .clk(clk), .rst(rst), .load(load), .bcd_data(bcd_data), .load_ack(load_ack0),
      .bcd_out(bcd_out0), .seg_in(seg_in0), .seg_out(seg_out0), .digit_sel(digit_sel0)
   );

   // Expected behaviour k cycles after reset release (slot = k%4, digit = (k/4)%2)
   function automatic logic [1:0] exp_sel(input int kk);
      if (kk % 4 == 0) exp_sel = 2'b00;
      else             exp_sel = ((kk / 4) % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [3:0] exp_bcd(input logic [7:0] sh, input int kk);
      exp_bcd = ((kk / 4) % 2 == 0) ? sh[3:0] : sh[7:4];
   endfunction

   function automatic logic [7:0] exp_seg(input logic [7:0] sh, input int kk, input bit lead);
      if (kk % 4 == 0)                                   exp_seg = 8'h00;
      else if (((kk / 4) % 2 == 1) && lead && sh[7:4] == 4'h0) exp_seg = 8'h00;
      else                                               exp_seg = dec(exp_bcd(sh, kk));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset();
      rst = 1'b1; load = 1'b0; bcd_data = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      k = 0;
   endtask

   task automatic test_reset();
      logic [7:0] sh;
      rst = 1'b1; load = 1'b0; bcd_data = 8'h00;
      tick();
      tick();
      if (digit_sel !== 2'b00) $display("FAIL reset_sel got %b exp 00", digit_sel); else n_pass++;
      n_checks++;
      if (seg_out !== 8'h00) $display("FAIL reset_seg got %h exp 00", seg_out); else n_pass++;
      n_checks++;
      if (bcd_out !== 4'h0) $display("FAIL reset_bcd got %h exp 0", bcd_out); else n_pass++;
      n_checks++;
      if (load_ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", load_ack); else n_pass++;
      n_checks++;
      rst = 1'b0;
      k = 0;
      sh = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (digit_sel !== exp_sel(k)) $display("FAIL scan_sel k=%0d got %b exp %b", k, digit_sel, exp_sel(k)); else n_pass++;
         n_checks++;
         if (seg_out !== exp_seg(sh, k, 1'b1)) $display("FAIL scan_seg k=%0d got %h exp %h", k, seg_out, exp_seg(sh, k, 1'b1)); else n_pass++;
         n_checks++;
         if (load_ack !== 1'b0) $display("FAIL scan_ack k=%0d got %b exp 0", k, load_ack); else n_pass++;
         n_checks++;
         tick();
      end
   endtask

   task automatic test_load_commit();
      logic [7:0] sh;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         load = (k == 2); bcd_data = 8'h42;
         sh = (k >= 8) ? 8'h42 : 8'h00;
         if (digit_sel !== exp_sel(k)) $display("FAIL commit_sel k=%0d got %b exp %b", k, digit_sel, exp_sel(k)); else n_pass++;
         n_checks++;
         if (seg_out !== exp_seg(sh, k, 1'b1)) $display("FAIL commit_seg k=%0d got %h exp %h", k, seg_out, exp_seg(sh, k, 1'b1)); else n_pass++;
         n_checks++;
         if (bcd_out !== exp_bcd(sh, k)) $display("FAIL commit_bcd k=%0d got %h exp %h", k, bcd_out, exp_bcd(sh, k)); else n_pass++;
         n_checks++;
         if (load_ack !== (k == 8)) $display("FAIL commit_ack k=%0d got %b exp %b", k, load_ack, (k == 8)); else n_pass++;
         n_checks++;
         tick();
      end
      load = 1'b0;
   endtask

   task automatic test_overwrite();
      logic [7:0] sh;
      int n_ack = 0;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         load = (k == 1) || (k == 3);
         bcd_data = (k == 1) ? 8'h12 : 8'h37;
         sh = (k >= 8) ? 8'h37 : 8'h00;
         n_ack += int'(load_ack);
         if (seg_out !== exp_seg(sh, k, 1'b1)) $display("FAIL overwrite_seg k=%0d got %h exp %h", k, seg_out, exp_seg(sh, k, 1'b1)); else n_pass++;
         n_checks++;
         if (bcd_out !== exp_bcd(sh, k)) $display("FAIL overwrite_bcd k=%0d got %h exp %h", k, bcd_out, exp_bcd(sh, k)); else n_pass++;
         n_checks++;
         if (load_ack !== (k == 8)) $display("FAIL overwrite_ack k=%0d got %b exp %b", k, load_ack, (k == 8)); else n_pass++;
         n_checks++;
         tick();
      end
      load = 1'b0;
      if (n_ack != 1) $display("FAIL overwrite_ack_count got %0d exp 1", n_ack); else n_pass++;
      n_checks++;
   endtask

   task automatic test_leading_zero();
      logic [7:0] sh;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         load = (k == 0); bcd_data = 8'h05;
         sh = (k >= 8) ? 8'h05 : 8'h00;
         if (seg_out !== exp_seg(sh, k, 1'b1)) $display("FAIL lz_lead1_seg k=%0d got %h exp %h", k, seg_out, exp_seg(sh, k, 1'b1)); else n_pass++;
         n_checks++;
         if (seg_out0 !== exp_seg(sh, k, 1'b0)) $display("FAIL lz_lead0_seg k=%0d got %h exp %h", k, seg_out0, exp_seg(sh, k, 1'b0)); else n_pass++;
         n_checks++;
         if (digit_sel0 !== exp_sel(k)) $display("FAIL lz_lead0_sel k=%0d got %b exp %b", k, digit_sel0, exp_sel(k)); else n_pass++;
         n_checks++;
         if (k == 9 && seg_out !== 8'h6D) $display("FAIL lz_digit0 got %h exp 6d", seg_out);
         if (k == 13 && seg_out !== 8'h00) $display("FAIL lz_digit1_blank got %h exp 00", seg_out);
         if (k == 13 && seg_out0 !== 8'h3F) $display("FAIL lz_digit1_shown got %h exp 3f", seg_out0);
         tick();
      end
      load = 1'b0;
   endtask

   task automatic test_boundary_collision();
      logic [7:0] sh;
      do_reset();
      for (int i = 0; i < 22; i++) begin
         load = (k == 2) || (k == 7);
         bcd_data = (k == 2) ? 8'h11 : 8'h99;
         sh = (k >= 16) ? 8'h99 : ((k >= 8) ? 8'h11 : 8'h00);
         if (seg_out !== exp_seg(sh, k, 1'b1)) $display("FAIL collide_seg k=%0d got %h exp %h", k, seg_out, exp_seg(sh, k, 1'b1)); else n_pass++;
         n_checks++;
         if (bcd_out !== exp_bcd(sh, k)) $display("FAIL collide_bcd k=%0d got %h exp %h", k, bcd_out, exp_bcd(sh, k)); else n_pass++;
         n_checks++;
         if (load_ack !== (k == 8 || k == 16)) $display("FAIL collide_ack k=%0d got %b exp %b", k, load_ack, (k == 8 || k == 16)); else n_pass++;
         n_checks++;
         tick();
      end
      load = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         load = (k == 2); bcd_data = 8'h42;
         tick();
      end
      load = 1'b0;
      rst = 1'b1;
      tick();
      if (load_ack !== 1'b0) $display("FAIL midrst_ack_in_reset got %b exp 0", load_ack); else n_pass++;
      n_checks++;
      tick();
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         if (seg_out !== exp_seg(8'h00, k, 1'b1)) $display("FAIL midrst_seg k=%0d got %h exp %h", k, seg_out, exp_seg(8'h00, k, 1'b1)); else n_pass++;
         n_checks++;
         if (digit_sel !== exp_sel(k)) $display("FAIL midrst_sel k=%0d got %b exp %b", k, digit_sel, exp_sel(k)); else n_pass++;
         n_checks++;
         if (load_ack !== 1'b0) $display("FAIL midrst_ack k=%0d got %b exp 0", k, load_ack); else n_pass++;
         n_checks++;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; bcd_data = 8'h00;
      test_reset();
      test_load_commit();
      test_overwrite();
      test_leading_zero();
      test_boundary_collision();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
